// File: rtl/total_exp_sched.sv
// Shared registered total-exponent unit arbitrating NREQ posit-decode requesters.
// Define TE_SCHED_ROUND_ROBIN_EN for round-robin selection; default is fixed priority (lowest index).
module total_exp_sched #(
    parameter int N    = 16,
    parameter int ES   = 1,
    parameter int NREQ = 4,
    localparam int K_SIZE  = $clog2(N) + 1,
    localparam int TE_SIZE = K_SIZE + ES + 1,
    localparam int ID_W    = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*K_SIZE-1:0] req_k,
    input  logic [NREQ*ES-1:0]     req_exp,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TE_SIZE-1:0]     out_te,
    output logic [ID_W-1:0]        out_id,
    output logic                   busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [TE_SIZE-1:0]   te_q, te_d;
    logic [ID_W-1:0]      id_q, id_d;

    logic                 can_accept;
    logic                 any_grant;
    logic [NREQ-1:0]      grant;
    logic [ID_W-1:0]      win_idx;
    logic [K_SIZE-1:0]    k_sel;
    logic [ES-1:0]        exp_sel;
    logic [TE_SIZE-1:0]   k_ext;
    logic [TE_SIZE-1:0]   te_calc;

`ifdef TE_SCHED_ROUND_ROBIN_EN
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      cand;
`endif

    assign can_accept = (state_q == EMPTY) | out_ready;

    always_comb begin
        grant     = '0;
        win_idx   = '0;
        any_grant = 1'b0;
`ifdef TE_SCHED_ROUND_ROBIN_EN
        cand      = '0;
        // Cyclic search starting at the pointer; first valid candidate wins.
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = ID_W'((int'(rr_ptr_q) + off) % NREQ);
            if (!any_grant && req_valid[cand]) begin
                any_grant   = 1'b1;
                win_idx     = cand;
                grant[cand] = 1'b1;
            end
        end
`else
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!any_grant && req_valid[i]) begin
                any_grant = 1'b1;
                win_idx   = ID_W'(i);
                grant[i]  = 1'b1;
            end
        end
`endif
        if (!can_accept || !rst_n) begin
            grant     = '0;
            any_grant = 1'b0;
        end
    end

    always_comb begin
        k_sel   = '0;
        exp_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                k_sel   = req_k[i*K_SIZE +: K_SIZE];
                exp_sel = req_exp[i*ES +: ES];
            end
        end
        k_ext   = {{(TE_SIZE-K_SIZE){k_sel[K_SIZE-1]}}, k_sel};
        te_calc = (k_ext << ES) + {{(TE_SIZE-ES){1'b0}}, exp_sel};
    end

    always_comb begin
        state_d = state_q;
        te_d    = te_q;
        id_d    = id_q;
        case (state_q)
            EMPTY: begin
                if (any_grant) begin
                    state_d = FULL;
                    te_d    = te_calc;
                    id_d    = win_idx;
                end
            end
            FULL: begin
                if (out_ready) begin
                    if (any_grant) begin
                        te_d = te_calc;
                        id_d = win_idx;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

`ifdef TE_SCHED_ROUND_ROBIN_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_grant) begin
            if (win_idx == ID_W'(NREQ-1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = win_idx + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            te_q    <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            te_q    <= te_d;
            id_q    <= id_d;
        end
    end

    assign req_ready = grant;
    assign out_valid = (state_q == FULL);
    assign busy      = out_valid;
    assign out_te    = te_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_total_exp_sched.sv
// Directed bench for total_exp_sched with an integer-level reference model checked every cycle.
module tb_total_exp_sched;
    localparam int N       = 16;
    localparam int ES      = 1;
    localparam int NREQ    = 4;
    localparam int K_SIZE  = $clog2(N) + 1;
    localparam int TE_SIZE = K_SIZE + ES + 1;
    localparam int ID_W    = $clog2(NREQ);

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*K_SIZE-1:0] req_k = '0;
    logic [NREQ*ES-1:0]     req_exp = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [TE_SIZE-1:0]     out_te;
    logic [ID_W-1:0]        out_id;
    logic                   busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: the result register contents and the fairness pointer.
    int  m_valid = 0, m_te = 0, m_id = 0, m_rr = 0;
    bit  started = 0;

    total_exp_sched #(.N(N), .ES(ES), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_k(req_k), .req_exp(req_exp), .out_valid(out_valid), .out_ready(out_ready),
        .out_te(out_te), .out_id(out_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int req_te(input int i);
        int k, e;
        k = $signed(req_k[i*K_SIZE +: K_SIZE]);
        e = int'(req_exp[i*ES +: ES]);
        return k * (1 << ES) + e;
    endfunction

    function automatic int model_winner();
        if (!rst_n) return -1;
        if (m_valid != 0 && !out_ready) return -1;
`ifdef TE_SCHED_ROUND_ROBIN_EN
        for (int off = 0; off < NREQ; off++)
            if (req_valid[(m_rr + off) % NREQ]) return (m_rr + off) % NREQ;
`else
        for (int i = 0; i < NREQ; i++)
            if (req_valid[i]) return i;
`endif
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        if (!rst_n) begin
            m_valid = 0; m_te = 0; m_id = 0; m_rr = 0;
        end else begin
            g = model_winner();
            if (g >= 0) begin
                m_valid = 1; m_te = req_te(g); m_id = g; m_rr = (g + 1) % NREQ;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
        started = 1;
    end

    always @(negedge clk) begin
        int g, te_act, exp_mask;
        if (started) begin
            g = model_winner();
            exp_mask = (g >= 0) ? (1 << g) : 0;
            te_act = $signed(out_te);
            check("model req_ready", int'(req_ready), exp_mask);
            check("model out_valid", int'(out_valid), m_valid);
            check("model busy", int'(busy), m_valid);
            check("model out_te", te_act, m_te);
            check("model out_id", int'(out_id), m_id);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input int k, input int e);
        req_valid[i] = v;
        req_k[i*K_SIZE +: K_SIZE] = K_SIZE'(k);
        req_exp[i*ES +: ES] = ES'(e);
    endtask

    task automatic corner(input int k, input int e, input int expv);
        set_req(0, 1'b1, k, e);
        tick();
        req_valid = '0;
        check("corner out_te", int'($signed(out_te)), expv);
    endtask

    initial begin
        int snap;
        // Reset with everyone requesting.
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i + 1, 1);
        tick(); tick();
        check("reset req_ready", int'(req_ready), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_te", int'(out_te), 0);
        check("reset out_id", int'(out_id), 0);
        req_valid = '0;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        // Single request from requester 1.
        set_req(1, 1'b1, -3, 1);
        #1;
        check("single req_ready", int'(req_ready), 4'b0010);
        tick();
        req_valid = '0;
        check("single out_valid", int'(out_valid), 1);
        check("single out_te bits", int'(out_te), 7'b1111011);
        check("single out_id", int'(out_id), 1);

        corner(7, 1, 15);
        corner(-16, 0, -32);
        corner(0, 1, 1);
        corner(-1, 1, -1);
        tick(); tick();
        check("idle out_valid", int'(out_valid), 0);
        check("idle out_te held", int'($signed(out_te)), -1);

        // Fresh pointer, then full contention.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i - 2, i % 2);
        for (int c = 0; c < 5; c++) begin
            tick();
`ifdef TE_SCHED_ROUND_ROBIN_EN
            check("contention out_id", int'(out_id), c % NREQ);
`else
            check("contention out_id", int'(out_id), 0);
`endif
        end

        // Backpressure while full, then drain and reload in one edge.
        req_valid = '0;
        out_ready = 1'b0;
        set_req(2, 1'b1, 2, 1);
        snap = int'(out_te);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall req_ready", int'(req_ready), 0);
            tick();
            check("stall out_te", int'(out_te), snap);
            check("stall out_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        #1;
        check("reload req_ready", int'(req_ready), 4'b0100);
        tick();
        req_valid = '0;
        check("reload out_valid", int'(out_valid), 1);
        check("reload out_te", int'($signed(out_te)), 5);
        check("reload out_id", int'(out_id), 2);

        // Reset while holding a stalled result.
        out_ready = 1'b0;
        set_req(1, 1'b1, 1, 0);
        tick();
        rst_n = 1'b0;
        tick();
        check("midreset out_valid", int'(out_valid), 0);
        check("midreset out_te", int'(out_te), 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i, 1);
        tick();
        check("post-reset first winner", int'(out_id), 0);
        tick();
`ifdef TE_SCHED_ROUND_ROBIN_EN
        check("post-reset second winner", int'(out_id), 1);
`else
        check("post-reset second winner", int'(out_id), 0);
`endif
        req_valid = '0;
        tick(); tick();
        check("final out_valid", int'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
